// File: rtl/yblock_cfg_sequencer_if.sv
// Configuration word stream between the LA/Wishbone glue and the yblock sequencer.
// The source drives valid/data; the sequencer answers with ready.
interface yblock_cfg_sequencer_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_data;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/yblock_cfg_sequencer.sv
// Configuration sequencer for one 16x16 asynchronous yblock: clears the block, then
// drives each config word as a timed data/spacer pair; passes run_vin through when idle.
module yblock_cfg_sequencer #(
  parameter int WORDS      = 16,
  parameter int SETTLE     = 4,
  parameter int RST_CYCLES = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start,
  input  logic                  abort,
  yblock_cfg_sequencer_if.slave cfg,
  input  logic [31:0]           run_vin,
  output logic                  blk_reset,
  output logic                  blk_cfg,
  output logic [31:0]           blk_vin,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_DRIVE, S_SPACER, S_DONE
  } state_e;

  localparam logic [7:0] RST_LAST    = 8'(RST_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [8:0] WORDS_W     = 9'(WORDS);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic        blk_reset_q, blk_reset_d;
  logic [31:0] word_q;
  logic        load_word;
  logic [8:0]  cnt_next;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_cnt_d = word_cnt_q;
    load_word  = 1'b0;
    cnt_next   = {1'b0, word_cnt_q} + 9'd1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CLEAR;
          cnt_d      = 8'd0;
          word_cnt_d = 8'd0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_LOAD;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_LOAD: begin
        if (cfg.cfg_valid) begin
          load_word = 1'b1;
          state_d   = S_DRIVE;
          cnt_d     = 8'd0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SPACER;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SPACER: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d      = 8'd0;
          word_cnt_d = cnt_next[7:0];
          state_d    = (cnt_next == WORDS_W) ? S_DONE : S_LOAD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition above, including start and the frame-complete check.
    if (abort) begin
      state_d    = S_IDLE;
      word_cnt_d = word_cnt_q;
    end

    blk_reset_d = (state_d == S_CLEAR);
  end

  // NOTE: state flops use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      word_cnt_q  <= 8'd0;
      blk_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_cnt_q  <= word_cnt_d;
      blk_reset_q <= blk_reset_d;
    end
  end

  // NOTE: the latched word is pure datapath, only visible in DRIVE after a load, so it carries no reset.
  always_ff @(posedge wb_clk_i) begin
    if (load_word) word_q <= cfg.cfg_data;
  end

  always_comb begin
    blk_vin = 32'd0;
    if (state_q == S_IDLE)       blk_vin = run_vin;
    else if (state_q == S_DRIVE) blk_vin = word_q;
  end

  assign cfg.cfg_ready = (state_q == S_LOAD);
  assign blk_cfg       = (state_q == S_CLEAR) || (state_q == S_LOAD) ||
                         (state_q == S_DRIVE) || (state_q == S_SPACER);
  assign blk_reset     = blk_reset_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_yblock_cfg_sequencer.sv
// Directed bench for yblock_cfg_sequencer: full frames, backpressure, abort,
// async reset, start while busy, and idle passthrough against a cycle schedule.
module tb_yblock_cfg_sequencer;

  localparam int WORDS      = 16;
  localparam int SETTLE     = 4;
  localparam int RST_CYCLES = 2;
  localparam int FRAME_DONE = 1 + RST_CYCLES + WORDS * (1 + 2 * SETTLE);  // 147

  localparam int ST_IDLE   = 0;
  localparam int ST_CLEAR  = 1;
  localparam int ST_LOAD   = 2;
  localparam int ST_DRIVE  = 3;
  localparam int ST_SPACER = 4;
  localparam int ST_DONE   = 5;

  localparam logic [31:0] RUN_PAT = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] run_vin;
  logic        blk_reset;
  logic        blk_cfg;
  logic [31:0] blk_vin;
  logic        busy;
  logic        done;
  logic [7:0]  word_cnt;
  logic        clr_acc;
  int          acc_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  yblock_cfg_sequencer_if cfg_if ();

  yblock_cfg_sequencer #(
    .WORDS(WORDS), .SETTLE(SETTLE), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start    (start),
    .abort    (abort),
    .cfg      (cfg_if.slave),
    .run_vin  (run_vin),
    .blk_reset(blk_reset),
    .blk_cfg  (blk_cfg),
    .blk_vin  (blk_vin),
    .busy     (busy),
    .done     (done),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  // Word source: presents word (accepted count + 1) and advances on each handshake.
  always @(posedge clk) begin
    if (clr_acc) acc_cnt <= 0;
    else if (cfg_if.cfg_valid && cfg_if.cfg_ready) acc_cnt <= acc_cnt + 1;
  end
  always_comb cfg_if.cfg_data = 32'(acc_cnt) + 32'd1;

  // Reference schedule: state, word count and driven word for cycle c after the start edge.
  function automatic void sched(input int c, input int gw, input int gl,
                                output int st, output int wc, output int wd);
    int t;
    int len;
    wd = 0;
    if (c <= RST_CYCLES) begin
      st = ST_CLEAR; wc = 0; return;
    end
    t = c - RST_CYCLES;
    for (int k = 0; k < WORDS; k++) begin
      len = 1 + ((k == gw) ? gl : 0);
      if (t <= len) begin st = ST_LOAD; wc = k; return; end
      t -= len;
      if (t <= SETTLE) begin st = ST_DRIVE; wc = k; wd = k + 1; return; end
      t -= SETTLE;
      if (t <= SETTLE) begin st = ST_SPACER; wc = k; return; end
      t -= SETTLE;
    end
    wc = WORDS;
    st = (t == 1) ? ST_DONE : ST_IDLE;
  endfunction

  function automatic logic [44:0] exp_vec(input int st, input int wc, input int wd);
    logic [31:0] vin;
    vin = (st == ST_DRIVE) ? 32'(wd) : ((st == ST_IDLE) ? run_vin : 32'd0);
    return {st != ST_IDLE, st == ST_CLEAR,
            (st == ST_CLEAR) || (st == ST_LOAD) || (st == ST_DRIVE) || (st == ST_SPACER),
            st == ST_LOAD, st == ST_DONE, 8'(wc), vin};
  endfunction

  function automatic logic [44:0] dut_vec();
    return {busy, blk_reset, blk_cfg, cfg_if.cfg_ready, done, word_cnt, blk_vin};
  endfunction

  task automatic begin_frame();
    @(negedge clk);
    clr_acc = 1'b1;
    @(negedge clk);
    clr_acc          = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    start            = 1'b1;
  endtask

  // Runs one frame cycle by cycle; gw/gl insert a valid gap before word gw,
  // restart_c re-asserts start mid-frame, abort_c pulses abort in that cycle.
  task automatic run_frame(input string name, input int gw, input int gl,
                           input int restart_c, input int abort_c);
    int st, wc, wd, endc, ls;
    logic [44:0] exp;
    logic [44:0] got;
    endc = (abort_c > 0) ? abort_c + 4 : FRAME_DONE + gl + 3;
    ls   = RST_CYCLES + 1 + gw * (1 + 2 * SETTLE);
    begin_frame();
    for (int c = 1; c <= endc; c++) begin
      @(negedge clk);
      if (abort_c > 0 && c > abort_c) begin
        sched(abort_c, gw, gl, st, wc, wd);
        st = ST_IDLE;
      end else begin
        sched(c, gw, gl, st, wc, wd);
      end
      exp = exp_vec(st, wc, wd);
      got = dut_vec();
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: got flags=%b cnt=%0d vin=%h, expected flags=%b cnt=%0d vin=%h",
                 name, c, got[44:40], got[39:32], got[31:0], exp[44:40], exp[39:32], exp[31:0]);
      end
      start            = (c == restart_c);
      abort            = (c == abort_c);
      cfg_if.cfg_valid = !(gw >= 0 && c >= ls && c < ls + gl);
    end
    start            = 1'b0;
    abort            = 1'b0;
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [44:0] exp;
    rst = 1'b1; start = 1'b0; abort = 1'b0; clr_acc = 1'b1;
    cfg_if.cfg_valid = 1'b0; run_vin = RUN_PAT;
    repeat (3) @(negedge clk);
    exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, RUN_PAT};
    tests_run++;
    if (dut_vec() !== exp) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h, expected %h", dut_vec(), exp);
    end
    rst = 1'b0; clr_acc = 1'b0;
    @(negedge clk);
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, RUN_PAT};
    tests_run++;
    if (dut_vec() !== exp) begin
      tests_failed++;
      $display("FAIL reset_release: got %h, expected %h", dut_vec(), exp);
    end
  endtask

  task automatic test_idle_passthrough();
    @(negedge clk);
    run_vin = 32'h1234_5678;
    #1;
    tests_run++;
    if (blk_vin !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL idle_pass_a: got %h, expected %h", blk_vin, 32'h1234_5678);
    end
    run_vin = RUN_PAT;
    #1;
    tests_run++;
    if (blk_vin !== RUN_PAT) begin
      tests_failed++;
      $display("FAIL idle_pass_b: got %h, expected %h", blk_vin, RUN_PAT);
    end
  endtask

  task automatic test_full_frame();
    run_frame("full_frame", -1, 0, -1, -1);
  endtask

  task automatic test_backpressure();
    run_frame("backpressure", 4, 10, -1, -1);
  endtask

  task automatic test_start_while_busy();
    run_frame("start_busy", -1, 0, 23, -1);
  endtask

  task automatic test_abort();
    run_frame("abort_word7", -1, 0, -1, 59);
    // The source keeps valid high while idle; nothing further may be consumed.
    cfg_if.cfg_valid = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (acc_cnt !== 7) begin
      tests_failed++;
      $display("FAIL abort_no_consume: got %0d words accepted, expected 7", acc_cnt);
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_abort_final_spacer();
    run_frame("abort_final", -1, 0, -1, FRAME_DONE - 1);
  endtask

  task automatic test_abort_start_idle();
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({busy, blk_cfg, blk_reset, done, word_cnt} !== {4'b0000, 8'd15}) begin
        tests_failed++;
        $display("FAIL abort_start_idle[%0d]: got busy=%b cfg=%b rst=%b done=%b cnt=%0d, expected 0 0 0 0 15",
                 i, busy, blk_cfg, blk_reset, done, word_cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [44:0] exp;
    begin_frame();
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 32'd0};
    tests_run++;
    if (dut_vec() !== exp) begin
      tests_failed++;
      $display("FAIL async_pre_spacer: got %h, expected %h", dut_vec(), exp);
    end
    #2 rst = 1'b1;
    #1;
    exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, RUN_PAT};
    tests_run++;
    if (dut_vec() !== exp) begin
      tests_failed++;
      $display("FAIL async_assert: got %h, expected %h", dut_vec(), exp);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    @(negedge clk);
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, RUN_PAT};
    tests_run++;
    if (dut_vec() !== exp) begin
      tests_failed++;
      $display("FAIL async_release: got %h, expected %h", dut_vec(), exp);
    end
  endtask

  initial begin
    test_reset();
    test_idle_passthrough();
    test_full_frame();
    test_backpressure();
    test_start_while_busy();
    test_abort();
    test_abort_final_spacer();
    test_abort_start_idle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
